// File: rtl/fp32_acc_feeder.sv
// Streaming FP32 sum-reduction controller driving a 3-stage pipelined adder.
// Optional build macro: SFU_ACC_ZERO_SKIP_EN (elements with exponent 0 are counted but not summed).
module fp32_acc_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] sum_data,
  output logic [CNT_WIDTH-1:0]  sum_count,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  output logic                  add_vld_in,
  output logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_result,
  input  logic                  add_vld_out
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW = $clog2(LANES + 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // at the rising edge; valid never waits on ready, and sum_valid holds until taken.
  typedef enum logic [2:0] {ACCUM, FLUSH, FOLD_ISSUE, FOLD_WAIT, OUT} state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         fold_i;
  logic [DATA_WIDTH-1:0] psum [LANES];
  logic [LANES-1:0]      psum_v;
  logic [IW-1:0]         inflight;

  logic                  hs;
  logic                  skip;
  logic                  cur_v;
  logic [DATA_WIDTH-1:0] cur;
  logic                  accum_issue;
  logic                  fold_issue;
  logic                  found_i;
  logic                  found_j;
  logic [PW-1:0]         fi;
  logic [PW-1:0]         fj;

  assign hs = in_valid & in_ready;

`ifdef SFU_ACC_ZERO_SKIP_EN
  assign skip = (in_data[30:23] == 8'h00);
`else
  assign skip = 1'b0;
`endif

  // A result arriving now was issued LANES cycles ago from the slot the pointer is on again.
  assign cur_v = add_vld_out | psum_v[ptr];
  assign cur   = add_vld_out ? add_result : psum[ptr];

  assign accum_issue = (state == ACCUM) & hs & ~skip & cur_v;

  always_comb begin
    found_i = 1'b0;
    found_j = 1'b0;
    fi      = '0;
    fj      = '0;
    for (int k = 0; k < LANES; k++) begin
      if (psum_v[k]) begin
        if (!found_i) begin
          fi      = PW'(k);
          found_i = 1'b1;
        end else if (!found_j) begin
          fj      = PW'(k);
          found_j = 1'b1;
        end
      end
    end
  end

  assign fold_issue = (state == FOLD_ISSUE) & found_j;

  // Issue is combinational so the adder sees vld_in in the same cycle as the slot decision.
  always_comb begin
    add_vld_in = accum_issue | fold_issue;
    add_a      = '0;
    add_b      = '0;
    if (accum_issue) begin
      add_a = in_data;
      add_b = cur;
    end else if (fold_issue) begin
      add_a = psum[fi];
      add_b = psum[fj];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      ptr       <= '0;
      fold_i    <= '0;
      psum_v    <= '0;
      inflight  <= '0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_count <= '0;
      add_en    <= 1'b0;
      for (int k = 0; k < LANES; k++) psum[k] <= '0;
    end else begin
      add_en <= 1'b1;
      case ({add_vld_in, add_vld_out})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      case (state)
        ACCUM: begin
          ptr      <= (ptr == PW'(LANES - 1)) ? '0 : ptr + 1'b1;
          in_ready <= 1'b1;
          if (hs) begin
            sum_count <= sum_count + 1'b1;
            if (skip) begin
              if (add_vld_out) begin
                psum[ptr]   <= add_result;
                psum_v[ptr] <= 1'b1;
              end
            end else if (!cur_v) begin
              psum[ptr]   <= in_data;
              psum_v[ptr] <= 1'b1;
            end else begin
              psum_v[ptr] <= 1'b0;
            end
            if (in_last) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end else if (add_vld_out) begin
            psum[ptr]   <= add_result;
            psum_v[ptr] <= 1'b1;
          end
        end

        FLUSH: begin
          ptr <= (ptr == PW'(LANES - 1)) ? '0 : ptr + 1'b1;
          if (add_vld_out) begin
            psum[ptr]   <= add_result;
            psum_v[ptr] <= 1'b1;
          end
          if (inflight == '0) state <= FOLD_ISSUE;
        end

        FOLD_ISSUE: begin
          if (found_j) begin
            psum_v[fi] <= 1'b0;
            psum_v[fj] <= 1'b0;
            fold_i     <= fi;
            state      <= FOLD_WAIT;
          end else begin
            sum_data  <= found_i ? psum[fi] : '0;
            sum_valid <= 1'b1;
            state     <= OUT;
          end
        end

        FOLD_WAIT: begin
          if (add_vld_out) begin
            psum[fold_i]   <= add_result;
            psum_v[fold_i] <= 1'b1;
            state          <= FOLD_ISSUE;
          end
        end

        OUT: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            sum_count <= '0;
            psum_v    <= '0;
            ptr       <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_acc_feeder.sv
// Bench for fp32_acc_feeder: behavioural 3-cycle adder plus an integer-sum reference model.
module tb_fp32_acc_feeder;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] sum_data;
  logic [15:0] sum_count;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_vld_in;
  logic        add_en;
  logic [31:0] add_result;
  logic        add_vld_out;

  int vectors;
  int miscompares;
  int n_adds;

  logic [31:0] exp_q[$];
  logic [15:0] cnt_q[$];
  int unsigned pkt_sum;
  int          pkt_cnt;

  fp32_acc_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sum_data(sum_data), .sum_count(sum_count), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .add_a(add_a), .add_b(add_b), .add_vld_in(add_vld_in), .add_en(add_en),
    .add_result(add_result), .add_vld_out(add_vld_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- number helpers (values are non-negative integers) ----------------
  function automatic int unsigned f2i(input logic [31:0] f);
    int          p;
    logic [31:0] m;
    if (f[30:23] == 8'h00) return 0;
    p = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    return m >> (23 - p);
  endfunction

  function automatic logic [31:0] i2f(input int unsigned n);
    int          p;
    logic [31:0] m;
    logic [7:0]  e;
    if (n == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 32; k++) if (n[k]) p = k;
    m = n << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  // ---------------- behavioural adder, 3-cycle latency, shares rst_n ----------------
  logic [31:0] r1, r2;
  logic        v1, v2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; add_vld_out <= 1'b0;
      r1 <= '0; r2 <= '0; add_result <= '0;
    end else begin
      v1 <= add_vld_in & add_en;
      r1 <= i2f(f2i(add_a) + f2i(add_b));
      v2 <= v1; r2 <= r1;
      add_vld_out <= v2; add_result <= r2;
    end
  end

  always @(posedge clk) if (rst_n && add_vld_in) n_adds++;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (called at a falling edge, return at a falling edge) ----------------
  task automatic send(input logic [31:0] d, input logic last);
    int guard;
    guard    = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Element feeds the reference model as well as the DUT.
  task automatic send_num(input logic [31:0] d, input logic last);
    pkt_sum += f2i(d);
    pkt_cnt++;
    if (last) begin
      exp_q.push_back(i2f(pkt_sum));
      cnt_q.push_back(16'(pkt_cnt));
      pkt_sum = 0;
      pkt_cnt = 0;
    end
    send(d, last);
  endtask

  task automatic expect_sum(input int hold);
    logic [31:0] ed;
    logic [15:0] ec;
    int          guard;
    ed    = exp_q.pop_front();
    ec    = cnt_q.pop_front();
    guard = 0;
    while (!sum_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("sum_valid_timeout", {31'd0, sum_valid}, 32'd1);
    check("sum_data", sum_data, ed);
    check("sum_count", {16'd0, sum_count}, {16'd0, ec});
    check("in_ready_in_out", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, sum_valid}, 32'd1);
      check("hold_data", sum_data, ed);
      check("hold_count", {16'd0, sum_count}, {16'd0, ec});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check("sum_valid_clear", {31'd0, sum_valid}, 32'd0);
    check("sum_count_clear", {16'd0, sum_count}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_sum_valid"}, {31'd0, sum_valid}, 32'd0);
    check({tag, "_sum_data"}, sum_data, 32'd0);
    check({tag, "_sum_count"}, {16'd0, sum_count}, 32'd0);
    check({tag, "_add_vld_in"}, {31'd0, add_vld_in}, 32'd0);
    check({tag, "_add_a"}, add_a, 32'd0);
    check({tag, "_add_b"}, add_b, 32'd0);
    check({tag, "_add_en"}, {31'd0, add_en}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_before;
    int len;
    int unsigned v;
    vectors   = 0;
    miscompares = 0;
    n_adds    = 0;
    pkt_sum   = 0;
    pkt_cnt   = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sum_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("add_en_after_reset", {31'd0, add_en}, 32'd1);

    // four 1.0 back-to-back, three adds in total
    n_before = n_adds;
    for (int i = 0; i < 4; i++) send_num(32'h3F800000, i == 3);
    expect_sum(0);
    check("four_ones_value", 32'h40800000, i2f(4));
    check("four_ones_adds", n_adds - n_before, 32'd3);

    // single element: passes through without touching the adder
    n_before = n_adds;
    exp_q.push_back(32'h3FC00000);
    cnt_q.push_back(16'd1);
    send(32'h3FC00000, 1'b1);
    expect_sum(0);
    check("single_adds", n_adds - n_before, 32'd0);

    // six 1.0 with a bubble after each element
    for (int i = 0; i < 6; i++) begin
      send_num(32'h3F800000, i == 5);
      @(negedge clk);
    end
    check("six_ones_model", exp_q[0], 32'h40C00000);
    expect_sum(0);

    // result held ten cycles before it is taken
    for (int i = 0; i < 3; i++) send_num(i2f(i + 2), i == 2);
    expect_sum(10);

    // reset in the middle of a packet
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;
    send_num(32'h3F800000, 1'b0);
    send_num(32'h3F800000, 1'b1);
    check("midreset_model", exp_q[0], 32'h40000000);
    expect_sum(0);

    // a zero element between two ones gives 2.0 in either build
    send_num(32'h3F800000, 1'b0);
    send_num(32'h00000000, 1'b0);
    send_num(32'h3F800000, 1'b1);
    expect_sum(0);

    // packet made only of zeros
    send_num(32'h00000000, 1'b0);
    send_num(32'h00000000, 1'b1);
    expect_sum(1);

    // randomized packets with bubbles and random consumer delay
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1000);
        send_num(i2f(v), i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      expect_sum($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
